// File: rtl/hazard_pkg.sv
// Shared types and constants for the LEGv8 hazard controller.
// Holds the hazard classification encoding and the register comparator.
package hazard_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] XZR = 5'd31;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    FLUSH  = 2'd2,
    FREEZE = 2'd3
  } hz_state_t;

  function automatic logic reg_eq(
    input logic [REG_W-1:0] a,
    input logic [REG_W-1:0] b
  );
    return a == b;
  endfunction

endpackage

// File: rtl/hazard_control_unit_sat_counter.sv
// Saturating up-counter with a dominant synchronous clear.
// Used for performance counters and the memory-wait watchdog.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && count != '1) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Stall / bubble / flush controller for the 5-stage LEGv8 pipeline.
// Combinational controls, registered classification and hazard counters.
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       if_id_rn,
  input  logic [4:0]       if_id_rm,
  input  logic             if_id_uses_rn,
  input  logic             if_id_uses_rm,
  input  logic [4:0]       id_ex_rd,
  input  logic             id_ex_mem_read,
  input  logic             ex_mem_access,
  input  logic             dmem_ready,
  input  logic             branch_taken,
  input  logic             cnt_clear,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             ex_mem_write,
  output logic             id_ex_bubble,
  output logic             ex_mem_bubble,
  output logic             mem_wb_bubble,
  output logic             if_id_flush,
  output logic [1:0]       hz_state,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] freeze_cnt
);

  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [WW-1:0] WAIT_MAX  = WW'(MAX_WAIT);
  localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

  logic            freeze;
  logic            load_use;
  logic            rn_hit;
  logic            rm_hit;
  hz_state_t       cls;
  hz_state_t       state_q;
  logic [WW-1:0]   wait_ctr;

  assign freeze = ex_mem_access && !dmem_ready;
  assign rn_hit = if_id_uses_rn && reg_eq(if_id_rn, id_ex_rd);
  assign rm_hit = if_id_uses_rm && reg_eq(if_id_rm, id_ex_rd);
  assign load_use = id_ex_mem_read && !reg_eq(id_ex_rd, XZR)
                    && (rn_hit || rm_hit);

  always_comb begin
    cls = RUN;
    if (freeze) begin
      cls = FREEZE;
    end else if (branch_taken) begin
      cls = FLUSH;
    end else if (load_use) begin
      cls = STALL;
    end
  end

  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_ex_write   = 1'b1;
    ex_mem_write  = 1'b1;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    mem_wb_bubble = 1'b0;
    if_id_flush   = 1'b0;
    unique case (1'b1)
      (cls == FREEZE): begin
        pc_write      = 1'b0;
        if_id_write   = 1'b0;
        id_ex_write   = 1'b0;
        ex_mem_write  = 1'b0;
        mem_wb_bubble = 1'b1;
      end
      (cls == FLUSH): begin
        if_id_flush   = 1'b1;
        id_ex_bubble  = 1'b1;
        ex_mem_bubble = 1'b1;
      end
      (cls == STALL): begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
    end else begin
      state_q <= cls;
    end
  end

  assign hz_state = state_q;

  // Timeout fires on the edge that closes the MAX_WAIT-th freeze cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_timeout <= 1'b0;
    end else if (cnt_clear) begin
      mem_timeout <= 1'b0;
    end else if (freeze && wait_ctr >= WAIT_LAST) begin
      mem_timeout <= 1'b1;
    end
  end

  sat_counter #(.W(WW)) u_wait (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (freeze && wait_ctr != WAIT_MAX),
    .clr     (!freeze),
    .count   (wait_ctr)
  );

  sat_counter #(.W(CNT_W)) u_stall (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (cls == STALL),
    .clr     (cnt_clear),
    .count   (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (cls == FLUSH),
    .clr     (cnt_clear),
    .count   (flush_cnt)
  );

  sat_counter #(.W(CNT_W)) u_freeze (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (cls == FREEZE),
    .clr     (cnt_clear),
    .count   (freeze_cnt)
  );

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit.
// Table of decode vectors plus hand sequences for multi-cycle behaviour.
module tb_hazard_control_unit;

  localparam logic [7:0] C_RUN    = 8'b1111_0000;
  localparam logic [7:0] C_STALL  = 8'b0011_1000;
  localparam logic [7:0] C_FLUSH  = 8'b1111_1101;
  localparam logic [7:0] C_FREEZE = 8'b0000_0010;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  if_id_rn, if_id_rm, id_ex_rd;
  logic        if_id_uses_rn, if_id_uses_rm;
  logic        id_ex_mem_read, ex_mem_access, dmem_ready;
  logic        branch_taken, cnt_clear;
  logic        pc_write, if_id_write, id_ex_write, ex_mem_write;
  logic        id_ex_bubble, ex_mem_bubble, mem_wb_bubble, if_id_flush;
  logic [1:0]  hz_state;
  logic        mem_timeout;
  logic [15:0] stall_cnt, flush_cnt, freeze_cnt;
  logic [7:0]  ctl;

  int checks = 0;
  int failures = 0;
  logic [1:0] sbq[$];

  hazard_control_unit #(.MAX_WAIT(16), .CNT_W(16)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .if_id_rn       (if_id_rn),
    .if_id_rm       (if_id_rm),
    .if_id_uses_rn  (if_id_uses_rn),
    .if_id_uses_rm  (if_id_uses_rm),
    .id_ex_rd       (id_ex_rd),
    .id_ex_mem_read (id_ex_mem_read),
    .ex_mem_access  (ex_mem_access),
    .dmem_ready     (dmem_ready),
    .branch_taken   (branch_taken),
    .cnt_clear      (cnt_clear),
    .pc_write       (pc_write),
    .if_id_write    (if_id_write),
    .id_ex_write    (id_ex_write),
    .ex_mem_write   (ex_mem_write),
    .id_ex_bubble   (id_ex_bubble),
    .ex_mem_bubble  (ex_mem_bubble),
    .mem_wb_bubble  (mem_wb_bubble),
    .if_id_flush    (if_id_flush),
    .hz_state       (hz_state),
    .mem_timeout    (mem_timeout),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt),
    .freeze_cnt     (freeze_cnt)
  );

  always #5 clk = ~clk;

  assign ctl = {pc_write, if_id_write, id_ex_write, ex_mem_write,
                id_ex_bubble, ex_mem_bubble, mem_wb_bubble, if_id_flush};

  typedef struct {
    logic [4:0] rn, rm;
    logic       urn, urm;
    logic [4:0] rd;
    logic       mr, acc, rdy, br;
    logic [7:0] ectl;
    logic [1:0] ecls;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    if_id_rn = v.rn;
    if_id_rm = v.rm;
    if_id_uses_rn = v.urn;
    if_id_uses_rm = v.urm;
    id_ex_rd = v.rd;
    id_ex_mem_read = v.mr;
    ex_mem_access = v.acc;
    dmem_ready = v.rdy;
    branch_taken = v.br;
  endtask

  // Apply one cycle: check controls before the edge, class after it.
  task automatic step(input vec_t v, input string nm);
    logic [1:0] e;
    drive(v);
    #2;
    chk(nm, {24'd0, ctl}, {24'd0, v.ectl});
    sbq.push_back(v.ecls);
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      chk("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sbq.pop_front();
      chk({nm, "_hz_state"}, {30'd0, hz_state}, {30'd0, e});
    end
  endtask

  function automatic vec_t mk(input logic [4:0] rn, rm, input logic urn, urm,
                              input logic [4:0] rd, input logic mr, acc, rdy,
                              br, input logic [7:0] ectl,
                              input logic [1:0] ecls);
    vec_t v;
    v.rn = rn; v.rm = rm; v.urn = urn; v.urm = urm; v.rd = rd;
    v.mr = mr; v.acc = acc; v.rdy = rdy; v.br = br;
    v.ectl = ectl; v.ecls = ecls;
    return v;
  endfunction

  initial begin
    vec_t run_v, lu_v, frz_br_v, fl_v, frz_v, rdy_v;
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 2'd0);
    tbl[1]  = mk(1, 0, 1, 0, 1, 1, 0, 0, 0, C_STALL, 2'd1);
    tbl[2]  = mk(31, 0, 1, 0, 31, 1, 0, 0, 0, C_RUN, 2'd0);
    tbl[3]  = mk(1, 0, 0, 0, 1, 1, 0, 0, 0, C_RUN, 2'd0);
    tbl[4]  = mk(2, 7, 0, 1, 7, 1, 0, 0, 0, C_STALL, 2'd1);
    tbl[5]  = mk(2, 7, 0, 1, 7, 0, 0, 0, 0, C_RUN, 2'd0);
    tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, C_FLUSH, 2'd2);
    tbl[7]  = mk(1, 0, 1, 0, 1, 1, 0, 0, 1, C_FLUSH, 2'd2);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, C_FREEZE, 2'd3);
    tbl[9]  = mk(1, 0, 1, 0, 1, 1, 1, 0, 1, C_FREEZE, 2'd3);
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, C_RUN, 2'd0);
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 1, 1, 1, C_FLUSH, 2'd2);
    tbl[12] = mk(5, 5, 1, 1, 0, 0, 0, 0, 0, C_RUN, 2'd0);
    tbl[13] = mk(3, 3, 1, 1, 4, 1, 0, 0, 0, C_RUN, 2'd0);

    run_v    = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, C_RUN, 2'd0);
    lu_v     = mk(1, 0, 1, 0, 1, 1, 0, 0, 0, C_STALL, 2'd1);
    frz_br_v = mk(0, 0, 0, 0, 0, 0, 1, 0, 1, C_FREEZE, 2'd3);
    fl_v     = mk(0, 0, 0, 0, 0, 0, 1, 1, 1, C_FLUSH, 2'd2);
    frz_v    = mk(0, 0, 0, 0, 0, 0, 1, 0, 0, C_FREEZE, 2'd3);
    rdy_v    = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, C_RUN, 2'd0);

    reset_n = 1'b0;
    cnt_clear = 1'b0;
    drive(run_v);
    #3;
    chk("rst_hz_state", {30'd0, hz_state}, 32'd0);
    chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("rst_flush_cnt", {16'd0, flush_cnt}, 32'd0);
    chk("rst_freeze_cnt", {16'd0, freeze_cnt}, 32'd0);
    chk("rst_timeout", {31'd0, mem_timeout}, 32'd0);
    #9;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 14; i++) begin
      step(tbl[i], $sformatf("vec%0d", i));
    end
    chk("tbl_stall_cnt", {16'd0, stall_cnt}, 32'd2);
    chk("tbl_flush_cnt", {16'd0, flush_cnt}, 32'd3);
    chk("tbl_freeze_cnt", {16'd0, freeze_cnt}, 32'd2);

    // Clear wins over a coincident stall event.
    cnt_clear = 1'b1;
    step(lu_v, "clr_stall");
    cnt_clear = 1'b0;
    chk("clr_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("clr_flush_cnt", {16'd0, flush_cnt}, 32'd0);
    chk("clr_freeze_cnt", {16'd0, freeze_cnt}, 32'd0);

    step(lu_v, "lu_stall");
    step(run_v, "lu_next");
    chk("lu_stall_cnt", {16'd0, stall_cnt}, 32'd1);

    for (int i = 0; i < 3; i++) begin
      step(frz_br_v, $sformatf("frz_br%0d", i));
    end
    step(fl_v, "frz_then_flush");
    chk("fb_freeze_cnt", {16'd0, freeze_cnt}, 32'd3);
    chk("fb_flush_cnt", {16'd0, flush_cnt}, 32'd1);

    for (int i = 0; i < 15; i++) begin
      step(frz_v, $sformatf("wd%0d", i));
    end
    chk("wd_before", {31'd0, mem_timeout}, 32'd0);
    step(frz_v, "wd15");
    chk("wd_at_max", {31'd0, mem_timeout}, 32'd1);
    chk("wd_freeze_cnt", {16'd0, freeze_cnt}, 32'd19);
    step(rdy_v, "wd_ready");
    chk("wd_sticky", {31'd0, mem_timeout}, 32'd1);
    cnt_clear = 1'b1;
    step(run_v, "wd_clear");
    cnt_clear = 1'b0;
    chk("wd_cleared", {31'd0, mem_timeout}, 32'd0);

    drive(lu_v);
    repeat (70000) @(posedge clk);
    #1;
    chk("sat_stall_cnt", {16'd0, stall_cnt}, 32'h0000_ffff);
    chk("sat_flush_cnt", {16'd0, flush_cnt}, 32'd0);

    for (int i = 0; i < 17; i++) begin
      step(frz_v, $sformatf("pre_rst%0d", i));
    end
    chk("pre_rst_timeout", {31'd0, mem_timeout}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_hz_state", {30'd0, hz_state}, 32'd0);
    chk("arst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("arst_freeze_cnt", {16'd0, freeze_cnt}, 32'd0);
    chk("arst_timeout", {31'd0, mem_timeout}, 32'd0);
    chk("arst_ctl", {24'd0, ctl}, {24'd0, C_FREEZE});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
# hazard_control_unit

Pipeline hazard controller for the 5-stage LEGv8 CPU; it produces the stall, bubble and flush controls that steer the pipeline registers. It is the counterpart of the forwarding logic:
- Forwarding resolves register dependences by selecting already-computed values.
- This block resolves the cases forwarding cannot: load-use dependences, data-memory wait states and taken branches resolved in MEM.
- It also tracks a watchdog on memory waits and exports saturating hazard performance counters.

## Interface
Parameters:
- MAX_WAIT, 16: consecutive freeze cycles after which mem_timeout sets.
- CNT_W, 16: performance counter width.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- if_id_rn, if_id_rm  input  5  source registers of the instruction in ID.
- if_id_uses_rn, if_id_uses_rm  input  1  ID instruction actually reads that source.
- id_ex_rd  input  5  destination register of the instruction in EX.
- id_ex_mem_read  input  1  EX instruction is a load.
- ex_mem_access  input  1  MEM instruction is a load or store.
- dmem_ready  input  1  data memory completes the access this cycle.
- branch_taken  input  1  MEM-stage branch resolved taken.
- cnt_clear  input  1  synchronous clear of counters and mem_timeout.
- pc_write, if_id_write, id_ex_write, ex_mem_write  output  1  register enables; 1 = update.
- id_ex_bubble, ex_mem_bubble, mem_wb_bubble  output  1  load all-zero control into that register.
- if_id_flush  output  1  zero the IF/ID instruction.
- hz_state  output  2  registered classification of the previous cycle.
- mem_timeout  output  1  sticky watchdog flag.
- stall_cnt, flush_cnt, freeze_cnt  output  CNT_W  saturating event counters.

## Operation
Each cycle is classified with priority FREEZE > FLUSH > STALL > RUN. The control outputs are combinational from the current inputs.

- **FREEZE** when ex_mem_access && !dmem_ready:
  - pc_write = if_id_write = id_ex_write = ex_mem_write = 0.
  - mem_wb_bubble = 1.
  - All other bubble and flush outputs = 0.
  - branch_taken and the load-use terms are ignored; they remain valid because the stages hold.
- **FLUSH** when branch_taken (not frozen):
  - pc_write = 1.
  - if_id_flush = id_ex_bubble = ex_mem_bubble = 1.
  - All write enables = 1.
- **STALL** (load-use) when id_ex_mem_read && id_ex_rd != XZR (31) and either (if_id_uses_rn && if_id_rn == id_ex_rd) or (if_id_uses_rm && if_id_rm == id_ex_rd):
  - pc_write = if_id_write = 0.
  - id_ex_bubble = 1.
  - Remaining enables = 1.
- **RUN**: all write enables = 1; all bubble and flush outputs = 0.

Registered state:
- hz_state captures the classification each edge, encoded RUN = 0, STALL = 1, FLUSH = 2, FREEZE = 3.
- wait_ctr increments on each FREEZE cycle and clears on any non-FREEZE cycle. It saturates at MAX_WAIT.
- mem_timeout sets when wait_ctr reaches MAX_WAIT. It then holds until cnt_clear or reset.
- stall_cnt, flush_cnt and freeze_cnt each increment on a cycle of their class and saturate at all-ones.
- cnt_clear zeroes all three counters and mem_timeout at the next edge. If a counted event occurs in the same cycle as cnt_clear, the clear wins and the event is not counted.

## Timing
- Control outputs have zero-cycle latency: combinational from the inputs and valid before the edge that uses them.
- hz_state, the counters and mem_timeout reflect a cycle's events one edge later.
- Reset (asynchronous, any time including mid-freeze):
  - hz_state = RUN.
  - wait_ctr, all counters and mem_timeout = 0.
  - Control outputs follow the RUN/FREEZE/... decode of the inputs; no state gates them.
- A load-use stall lasts exactly 1 cycle. The next cycle ID/EX holds a bubble, so id_ex_mem_read = 0.
- Branch taken together with load-use: FLUSH; the stall is discarded with the flushed instruction.
- Branch taken during FREEZE: the flush is applied on the first cycle dmem_ready = 1.
- Watchdog: mem_timeout asserts on the edge ending the MAX_WAIT-th consecutive FREEZE cycle.

## Structure
- Shared package hazard_pkg holds:
  - hz_state_t enum (RUN, STALL, FLUSH, FREEZE) with the encoding above.
  - XZR = 5'd31.
  - REG_W = 5.
- Sub-module sat_counter, parameterised width, with inc and clr inputs, clr dominant.
  - Instantiated three times for the performance counters.
  - Instantiated once, width $clog2(MAX_WAIT+1), for wait_ctr.
- Register-number equality reuses the existing 5-bit comparator.

## Test plan
- Load X1 in EX (id_ex_rd = 1, mem_read = 1), ID reads rn = 1 with uses_rn = 1:
  - Stall cycle: pc_write = 0, if_id_write = 0, id_ex_bubble = 1.
  - Next cycle: RUN.
  - stall_cnt = 1.
- Same as above but id_ex_rd = 31, or uses_rn = 0 → RUN; no stall.
- ex_mem_access = 1, dmem_ready = 0 for 3 cycles with branch_taken = 1:
  - 3 FREEZE cycles with all enables 0 and mem_wb_bubble = 1.
  - Then a FLUSH cycle.
  - freeze_cnt = 3, flush_cnt = 1.
- Hold FREEZE for 16 cycles (MAX_WAIT = 16):
  - mem_timeout = 1 after the 16th edge and stays 1 after dmem_ready.
  - cnt_clear clears it.
- Drive 70000 stall cycles → stall_cnt saturates at 16'hFFFF.
- Assert reset_n low mid-FREEZE:
  - All counters, mem_timeout and hz_state = 0 immediately, without waiting for a clock edge.
